// File: rtl/sum_acc_pkg.sv
// Shared types and default sizes for the adder-result frame accumulator.
package sum_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int N_DEF     = 16;
  localparam int W_DEF     = 24;
  localparam int COUNT_DEF = 8;

endpackage

// File: rtl/sum_acc_add.sv
// Combinational W-bit adder with carry-out detect.
// Optional macro SUM_ACC_SATURATE_EN clamps the result to all-ones on carry-out.
module sum_acc_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[W];

`ifdef SUM_ACC_SATURATE_EN
  // A saturated total plus any nonzero operand carries again, so it stays pinned.
  assign sum = carry ? {W{1'b1}} : full[W-1:0];
`else
  assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/sum_frame_accumulator.sv
// Accumulates COUNT adder result words {cout, sum} into a W-bit frame total.
// Optional macro SUM_ACC_SATURATE_EN selects saturating instead of wrapping overflow.
module sum_frame_accumulator
  import sum_acc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int COUNT = COUNT_DEF,
  localparam int CW   = $clog2(COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_sum,
  input  logic          in_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_acc,
  output logic          out_ovf,
  output logic [CW-1:0] out_cnt
);

  state_t        state_reg, state_next;
  logic [W-1:0]  acc_reg, acc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ovf_reg, ovf_next;

  logic [W-1:0]  operand;
  logic [W-1:0]  add_sum;
  logic          add_carry;

  assign operand = W'({in_cout, in_sum});

  sum_acc_add #(.W(W)) u_add (
    .a     (acc_reg),
    .b     (operand),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  // clear overrides both handshakes, including discarding a finished frame.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    if (clear) begin
      state_next = ACCUM;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (in_valid) begin
            acc_next = add_sum;
            ovf_next = ovf_reg | add_carry;
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(COUNT - 1)) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
          end
        end
        default: state_next = ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == DONE);
  assign out_acc   = acc_reg;
  assign out_ovf   = ovf_reg;
  assign out_cnt   = cnt_reg;

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Directed bench: three accumulator instances (W=8/COUNT=4, W=6/COUNT=4, W=8/COUNT=1).
module tb_sum_frame_accumulator;

  logic clk;
  logic rst_n;

  // instance a: N=4, W=8, COUNT=4
  logic       a_clear, a_in_valid, a_in_ready, a_in_cout, a_out_valid, a_out_ready, a_out_ovf;
  logic [3:0] a_in_sum;
  logic [7:0] a_out_acc;
  logic [2:0] a_out_cnt;
  // instance b: N=4, W=6, COUNT=4
  logic       b_clear, b_in_valid, b_in_ready, b_in_cout, b_out_valid, b_out_ready, b_out_ovf;
  logic [3:0] b_in_sum;
  logic [5:0] b_out_acc;
  logic [2:0] b_out_cnt;
  // instance c: N=4, W=8, COUNT=1
  logic       c_clear, c_in_valid, c_in_ready, c_in_cout, c_out_valid, c_out_ready, c_out_ovf;
  logic [3:0] c_in_sum;
  logic [7:0] c_out_acc;
  logic [0:0] c_out_cnt;

  int checks;
  int errors;

  sum_frame_accumulator #(.N(4), .W(8), .COUNT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sum(a_in_sum), .in_cout(a_in_cout), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_acc(a_out_acc), .out_ovf(a_out_ovf), .out_cnt(a_out_cnt)
  );

  sum_frame_accumulator #(.N(4), .W(6), .COUNT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sum(b_in_sum), .in_cout(b_in_cout), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_acc(b_out_acc), .out_ovf(b_out_ovf), .out_cnt(b_out_cnt)
  );

  sum_frame_accumulator #(.N(4), .W(8), .COUNT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_sum(c_in_sum), .in_cout(c_in_cout), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_acc(c_out_acc), .out_ovf(c_out_ovf), .out_cnt(c_out_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_acc !== 8'd0) begin errors++; $display("FAIL reset_out_acc: got %0d expected 0", a_out_acc); end
    checks++; if (a_out_cnt !== 3'd0) begin errors++; $display("FAIL reset_out_cnt: got %0d expected 0", a_out_cnt); end
    checks++; if (a_out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", a_out_ovf); end
    rst_n = 1'b1;
    tick();
    a_in_valid = 1'b1; a_in_sum = 4'd3; a_in_cout = 1'b0;
    tick();
    tick();
    a_in_valid = 1'b0;
    $display("reset: two beats accepted, cnt=%0d acc=%0d", a_out_cnt, a_out_acc);
    checks++; if (a_out_cnt !== 3'd2) begin errors++; $display("FAIL midframe_cnt: got %0d expected 2", a_out_cnt); end
    checks++; if (a_out_acc !== 8'd6) begin errors++; $display("FAIL midframe_acc: got %0d expected 6", a_out_acc); end
    // assert reset between clock edges; outputs must drop without a clk edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_cnt !== 3'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d expected 0", a_out_cnt); end
    checks++; if (a_out_acc !== 8'd0) begin errors++; $display("FAIL async_reset_acc: got %0d expected 0", a_out_acc); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid: got %b expected 0", a_out_valid); end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    a_in_valid = 1'b1; a_in_sum = 4'hF; a_in_cout = 1'b1;
    tick(); tick(); tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_acc !== 8'd93) begin errors++; $display("FAIL b2b_partial_acc: got %0d expected 93", a_out_acc); end
    tick();
    a_in_valid = 1'b0;
    $display("back_to_back: frame acc=%0d ovf=%b cnt=%0d", a_out_acc, a_out_ovf, a_out_cnt);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid: got %b expected 1", a_out_valid); end
    checks++; if (a_out_acc !== 8'd124) begin errors++; $display("FAIL b2b_out_acc: got %0d expected 124", a_out_acc); end
    checks++; if (a_out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_out_ovf: got %b expected 0", a_out_ovf); end
    checks++; if (a_out_cnt !== 3'd4) begin errors++; $display("FAIL b2b_out_cnt: got %0d expected 4", a_out_cnt); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b expected 0", a_in_ready); end
  endtask

  task automatic test_backpressure();
    // inputs offered while DONE must be ignored
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_sum = 4'd1; a_in_cout = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (a_out_acc !== 8'd124) begin errors++; $display("FAIL bp_hold_acc[%0d]: got %0d expected 124", i, a_out_acc); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", i, a_in_ready); end
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    a_in_valid = 1'b0;
    $display("backpressure: frame released, valid=%b cnt=%0d", a_out_valid, a_out_cnt);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_out_cnt !== 3'd0) begin errors++; $display("FAIL bp_release_cnt: got %0d expected 0", a_out_cnt); end
    checks++; if (a_out_acc !== 8'd0) begin errors++; $display("FAIL bp_release_acc: got %0d expected 0", a_out_acc); end
  endtask

  task automatic test_overflow();
    logic [5:0] exp_acc;
`ifdef SUM_ACC_SATURATE_EN
    exp_acc = 6'd63;
`else
    exp_acc = 6'd60;
`endif
    b_in_valid = 1'b1; b_in_sum = 4'hF; b_in_cout = 1'b1;
    tick(); tick();
    checks++; if (b_out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b expected 0", b_out_ovf); end
    tick(); tick();
    b_in_valid = 1'b0;
    $display("overflow: frame acc=%0d ovf=%b", b_out_acc, b_out_ovf);
    checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", b_out_valid); end
    checks++; if (b_out_acc !== exp_acc) begin errors++; $display("FAIL ovf_acc: got %0d expected %0d", b_out_acc, exp_acc); end
    checks++; if (b_out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", b_out_ovf); end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    checks++; if (b_out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", b_out_ovf); end
  endtask

  task automatic test_gapped_clear();
    a_in_valid = 1'b1; a_in_sum = 4'd3; a_in_cout = 1'b0;
    tick();
    a_in_valid = 1'b0; a_in_sum = 4'd9;
    tick();
    a_in_valid = 1'b1; a_in_sum = 4'd5;
    tick();
    checks++; if (a_out_cnt !== 3'd2) begin errors++; $display("FAIL gap_cnt: got %0d expected 2", a_out_cnt); end
    checks++; if (a_out_acc !== 8'd8) begin errors++; $display("FAIL gap_acc: got %0d expected 8", a_out_acc); end
    a_clear = 1'b1; a_in_sum = 4'd7;
    tick();
    a_clear = 1'b0;
    $display("gapped_clear: after clear cnt=%0d acc=%0d", a_out_cnt, a_out_acc);
    checks++; if (a_out_cnt !== 3'd0) begin errors++; $display("FAIL clear_cnt: got %0d expected 0", a_out_cnt); end
    checks++; if (a_out_acc !== 8'd0) begin errors++; $display("FAIL clear_acc: got %0d expected 0", a_out_acc); end
    a_in_sum = 4'd1;
    tick(); tick(); tick(); tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL ones_valid: got %b expected 1", a_out_valid); end
    checks++; if (a_out_acc !== 8'd4) begin errors++; $display("FAIL ones_acc: got %0d expected 4", a_out_acc); end
    // clear wins over out_ready and discards the pending frame
    a_clear = 1'b1; a_out_ready = 1'b1;
    tick();
    a_clear = 1'b0; a_out_ready = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL clear_done_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_cnt !== 3'd0) begin errors++; $display("FAIL clear_done_cnt: got %0d expected 0", a_out_cnt); end
  endtask

  task automatic test_count_one();
    c_in_valid = 1'b1; c_in_sum = 4'h9; c_in_cout = 1'b0;
    tick();
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    $display("count_one: frame acc=%0d cnt=%0d", c_out_acc, c_out_cnt);
    checks++; if (c_out_valid !== 1'b1) begin errors++; $display("FAIL c1_valid: got %b expected 1", c_out_valid); end
    checks++; if (c_out_acc !== 8'd9) begin errors++; $display("FAIL c1_acc: got %0d expected 9", c_out_acc); end
    checks++; if (c_out_cnt !== 1'd1) begin errors++; $display("FAIL c1_cnt: got %0d expected 1", c_out_cnt); end
    tick();
    c_out_ready = 1'b0;
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL c1_in_ready: got %b expected 1", c_in_ready); end
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL c1_released: got %b expected 0", c_out_valid); end
    c_in_valid = 1'b1; c_in_sum = 4'h2; c_in_cout = 1'b1;
    tick();
    c_in_valid = 1'b0;
    $display("count_one: second frame acc=%0d", c_out_acc);
    checks++; if (c_out_acc !== 8'd18) begin errors++; $display("FAIL c1_second_acc: got %0d expected 18", c_out_acc); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    checks = 0; errors = 0;
    a_clear = 0; a_in_valid = 0; a_in_sum = 0; a_in_cout = 0; a_out_ready = 0;
    b_clear = 0; b_in_valid = 0; b_in_sum = 0; b_in_cout = 0; b_out_ready = 0;
    c_clear = 0; c_in_valid = 0; c_in_sum = 0; c_in_cout = 0; c_out_ready = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_gapped_clear();
    test_count_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_frame_accumulator.md
Name: sum_frame_accumulator

Overview:
- Downstream consumer of the N-bit ripple full adder.
- Takes each {cout, sum} result word over a valid/ready handshake and accumulates COUNT consecutive words into a W-bit running total.
- Presents the frame total, with a sticky overflow flag, on an output valid/ready handshake.
- Used to check adder throughput and to build checksums over adder result streams.

Parameters:
- N, 16, width of the adder sum word.
- W, 24, accumulator width; legal range W >= N+1.
- COUNT, 8, adder results per frame; legal range COUNT >= 1.
- CW, $clog2(COUNT+1), width of the frame counter (derived, not overridden).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous frame abort/flush.
- in_valid  input  1  adder result present.
- in_ready  output  1  block accepts a result this cycle.
- in_sum  input  N  adder sum.
- in_cout  input  1  adder carry-out.
- out_valid  output  1  frame total available.
- out_ready  input  1  consumer accepts the total.
- out_acc  output  W  frame total.
- out_ovf  output  1  sticky overflow for the frame.
- out_cnt  output  CW  results accepted in the current frame.

Behaviour:
- Reset (rst_n low, async):
  - state=ACCUM.
  - acc=0, cnt=0, ovf=0.
  - in_ready=1, out_valid=0, out_acc=0, out_ovf=0, out_cnt=0.
- Operand value is {in_cout, in_sum}, zero-extended from N+1 bits to W bits.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Handshake (in_valid & in_ready): acc <= acc + value, cnt <= cnt+1.
  - If the addition carries out of bit W-1: ovf <= 1 and acc wraps mod 2^W.
  - When the accepted word is the COUNT-th (cnt == COUNT-1 before the update): next state is DONE.
- State DONE:
  - in_ready=0, out_valid=1.
  - out_acc=acc and out_ovf=ovf, both held stable until accepted.
  - On out_ready: acc=0, cnt=0, ovf=0, next state ACCUM.
  - No input is accepted in the same cycle as out_ready; first new accept is one cycle later.
- Latency: out_valid rises exactly 1 cycle after the COUNT-th input handshake.
- Throughput: one input word per cycle in ACCUM; one dead cycle per frame.
- in_ready and out_valid are decoded from the registered state only; no combinational path from in_valid or out_ready.
- out_cnt=cnt in all states; it equals COUNT in DONE.
- clear has priority over every handshake in the same cycle:
  - acc, cnt, ovf cleared; state=ACCUM.
  - A pending DONE result is discarded.
  - An input presented in the clear cycle is not accumulated, even with in_valid high.
- in_valid low in ACCUM: state is held, no change.
- COUNT=1: every accepted word produces a frame.
- Reset mid-frame: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: SUM_ACC_SATURATE_EN.
- Defined: on carry out of bit W-1, acc <= {W{1'b1}} (saturates at 2^W-1), ovf <= 1. Once saturated, acc stays at 2^W-1 for the rest of the frame.
- Undefined: wrap-around mod 2^W as described above; ovf behaviour is unchanged.

Decomposition:
- Shared package sum_acc_pkg:
  - state enum {ACCUM, DONE}, 1-bit encoding.
  - default parameter constants (N_DEF=16, W_DEF=24, COUNT_DEF=8).
- One natural sub-module, sum_acc_add: W-bit adder with overflow detect and the saturate option. It is combinational, instantiated once and reusable by sibling blocks.
- Counter and FSM stay in the top module.

Test Plan (N=4, W=8, COUNT=4 unless stated):
- Reset: rst_n low mid-frame after 2 accepts -> out_valid=0, in_ready=1, out_cnt=0, out_acc=0, asynchronously, before the next clk edge.
- Back-to-back inputs: 4 consecutive beats in_sum=4'hF, in_cout=1 (value 31) -> out_valid high the cycle after beat 4, out_acc=124, out_ovf=0, out_cnt=4, in_ready=0.
- Backpressure: hold out_ready=0 for 5 cycles -> out_acc=124 stable, in_ready=0 throughout; out_ready=1 -> next cycle out_valid=0, in_ready=1, out_cnt=0.
- Overflow (W=6): same 4 beats of 31:
  - SUM_ACC_SATURATE_EN undefined -> out_acc=60 (124 mod 64), out_ovf=1.
  - SUM_ACC_SATURATE_EN defined -> out_acc=63, out_ovf=1.
- Gapped input with clear: in_valid toggling 1,0,1 (values 3, then 5) then clear=1 together with in_valid=1 (value 7) -> out_cnt=0, acc=0; then 4 beats of value 1 -> out_acc=4.
- COUNT=1: in_sum=4'h9, in_cout=0 -> out_acc=9 one cycle later; out_ready=1 the same cycle -> in_ready returns 1 the following cycle.
